// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC. A start request loads the
// vector (pre-rotated into the +/-90 degree convergence range), then one
// shift-and-add micro-rotation runs per clock. The rotated vector comes out
// without gain correction. The downstream x1/K stage takes x_out/y_out while
// valid is high.
module cordic_rotator #(
  parameter int WIDTH = 16,
  parameter int ITERS = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic [WIDTH+1:0] x_out,
  output logic [WIDTH+1:0] y_out,
  output logic             busy,
  output logic             valid
);

  // Two guard bits hold the CORDIC gain (~1.647) and the pre-rotation
  // negation of -2^(WIDTH-1).
  localparam int XW = WIDTH + 2;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [CW-1:0]    LAST_I  = CW'(ITERS - 1);

  // Elaboration-time arctangent: round(atan(2^-i) * 2^(WIDTH-1) / pi).
  // i = 0 is exactly pi/4. For i >= 1 the argument is at most 0.5, so the
  // Taylor series converges well inside 40 terms.
  function automatic logic [WIDTH-1:0] atan_const(input int i);
    real t;
    real term;
    real acc;
    real scale;
    logic [WIDTH-1:0] res;
    res = '0;
    if (i == 0) begin
      res[WIDTH-3] = 1'b1;
    end else begin
      t = 1.0;
      for (int k = 0; k < i; k++) t = t / 2.0;
      acc  = 0.0;
      term = t;
      for (int k = 0; k < 40; k++) begin
        if (k % 2 == 0) acc = acc + term / real'(2 * k + 1);
        else            acc = acc - term / real'(2 * k + 1);
        term = term * t * t;
      end
      scale = 1.0;
      for (int k = 0; k < WIDTH - 1; k++) scale = scale * 2.0;
      res = WIDTH'($rtoi(acc * scale / 3.14159265358979323846 + 0.5));
    end
    return res;
  endfunction

  logic [WIDTH-1:0] atan_tab [ITERS];

  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    localparam logic [WIDTH-1:0] ATAN_G = atan_const(g);
    assign atan_tab[g] = ATAN_G;
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d;
  logic signed [XW-1:0]  y_q, y_d;
  logic [WIDTH-1:0]      z_q, z_d;
  logic [CW-1:0]         i_q, i_d;

  // Load values after the quadrant pre-rotation.
  logic signed [XW-1:0]  x_ext, y_ext;
  logic signed [XW-1:0]  x_ld, y_ld;
  logic [WIDTH-1:0]      z_ld;

  // One micro-rotation applied to the current registers.
  logic signed [XW-1:0]  x_sh, y_sh;
  logic signed [XW-1:0]  x_rot, y_rot;
  logic [WIDTH-1:0]      z_rot;
  logic [WIDTH-1:0]      atan_cur;
  logic                  d_pos;

  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

  // Fold angles outside +/-90 degrees by a quarter turn so that the
  // micro-rotation sequence can converge.
  // NOTE: every output of a combinational block is given a default first, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    x_ld = x_ext;
    y_ld = y_ext;
    z_ld = z_in;
    unique case (z_in[WIDTH-1:WIDTH-2])
      2'b01: begin
        x_ld = -y_ext;
        y_ld = x_ext;
        z_ld = z_in - QUARTER;
      end
      2'b10: begin
        x_ld = y_ext;
        y_ld = -x_ext;
        z_ld = z_in + QUARTER;
      end
      default: ;
    endcase
  end

  // Micro-rotation i: the direction follows the sign of the residual angle.
  // Both updates read the pre-update registers.
  always_comb begin
    atan_cur = atan_tab[i_q];
    d_pos    = ~z_q[WIDTH-1];
    x_sh     = x_q >>> i_q;
    y_sh     = y_q >>> i_q;
    if (d_pos) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_cur;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_cur;
    end
  end

  // Next-state logic. A start request is accepted in IDLE and in DONE, and is
  // ignored while the engine is rotating.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          x_d     = x_ld;
          y_d     = y_ld;
          z_d     = z_ld;
          i_d     = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (i_q == LAST_I) begin
          i_d     = '0;
          state_d = DONE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        i_d     = '0;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset clears them all, and
  // an in-flight request is dropped.
  // NOTE: sequential state uses non-blocking assignment so that every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign busy  = (state_q == ROTATE);
  assign valid = (state_q == DONE);

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator. It uses directed and random vectors.
// The expected outputs come from a real-valued rotation scaled by the exact
// CORDIC gain.
module tb_cordic_rotator;

  localparam int WIDTH = 16;
  localparam int ITERS = 12;
  localparam int XW    = WIDTH + 2;
  localparam real PI   = 3.14159265358979323846;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] x_in, y_in, z_in;
  logic [XW-1:0]    x_out, y_out;
  logic             busy, valid;

  int  n_checks = 0;
  int  n_errors = 0;
  real gain;
  real full_scale;

  cordic_rotator #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .x_out (x_out),
    .y_out (y_out),
    .busy  (busy),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Ideal rotation of (x, y) by angle z, scaled by the CORDIC gain.
  task automatic model(input int x, input int y, input int z,
                       output real xr, output real yr);
    real th;
    th = real'(z) * PI / full_scale;
    xr = gain * (real'(x) * $cos(th) - real'(y) * $sin(th));
    yr = gain * (real'(x) * $sin(th) + real'(y) * $cos(th));
  endtask

  function automatic longint rnd(input real r);
    return longint'($rtoi((r >= 0.0) ? r + 0.5 : r - 0.5));
  endfunction

  task automatic drive(input int x, input int y, input int z);
    x_in = x[WIDTH-1:0];
    y_in = y[WIDTH-1:0];
    z_in = z[WIDTH-1:0];
  endtask

  // Counts edges after the accept edge until valid appears (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Compares the outputs against the model. When mag_tol is set, the bound
  // also covers the residual angle left after the last micro-rotation
  // (at most about atan(2^-(ITERS-1)) plus the table rounding, taken as 8 LSB
  // of angle) times the output magnitude.
  task automatic check_result(input string tag, input int x, input int y,
                              input int z, input longint tol_base,
                              input bit mag_tol);
    real    xr, yr, mag;
    longint tol;
    model(x, y, z, xr, yr);
    tol = tol_base;
    if (mag_tol) begin
      mag = gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      tol = tol + longint'($rtoi(mag * 8.0 * PI / full_scale + 1.0));
    end
    check({tag, "_x"}, longint'($signed(x_out)), rnd(xr), tol);
    check({tag, "_y"}, longint'($signed(y_out)), rnd(yr), tol);
  endtask

  task automatic one_shot(input string tag, input int x, input int y,
                          input int z, input longint tol_base,
                          input bit mag_tol);
    int lat;
    @(negedge clk);
    drive(x, y, z);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, longint'(busy), 1);
    wait_valid(lat);
    check({tag, "_lat"}, longint'(lat), ITERS);
    check_result(tag, x, y, z, tol_base, mag_tol);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, longint'(valid), 0);
    check({tag, "_idle"}, longint'(busy), 0);
  endtask

  initial begin
    int lat;
    int lat2;
    int cnt;
    int rx, ry, rz;

    gain = 1.0;
    for (int i = 0; i < ITERS; i++) gain = gain * $sqrt(1.0 + 1.0 / (4.0 ** i));
    full_scale = 2.0 ** (WIDTH - 1);

    rst_n = 1'b0;
    start = 1'b0;
    drive(0, 0, 0);
    #12;
    check("rst_x",     longint'($signed(x_out)), 0);
    check("rst_y",     longint'($signed(y_out)), 0);
    check("rst_busy",  longint'(busy), 0);
    check("rst_valid", longint'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a request mid-rotation with an asynchronous reset.
    @(negedge clk);
    drive(16384, 0, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_x",     longint'($signed(x_out)), 0);
    check("abort_y",     longint'($signed(y_out)), 0);
    check("abort_busy",  longint'(busy), 0);
    check("abort_valid", longint'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) cnt++;
    end
    check("abort_no_valid", longint'(cnt), 0);

    // Directed vectors, including both pre-rotation paths.
    one_shot("z0",    16384, 0,      0, 12, 1'b0);
    one_shot("z45",   16384, 0,   8192, 12, 1'b0);
    one_shot("z90",   16384, 0,  16384, 12, 1'b0);
    one_shot("zm180", 16384, 0, -32768, 12, 1'b0);
    one_shot("neg_full", -32768, -32768, 12000, ITERS + 2, 1'b1);

    // start held high: inputs that change during ROTATE are ignored, and DONE
    // loads the next request back-to-back.
    @(negedge clk);
    drive(10000, -5000, 3000);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("held_busy", longint'(busy), 1);
    drive(-7000, 9000, -20000);
    wait_valid(lat);
    check("held_lat", longint'(lat), ITERS);
    check_result("held_a", 10000, -5000, 3000, ITERS + 2, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_busy",  longint'(busy), 1);
    check("b2b_valid", longint'(valid), 0);
    drive(1, 2, 3);
    wait_valid(lat);
    check("b2b_lat", longint'(lat), ITERS);
    check_result("held_b", -7000, 9000, -20000, ITERS + 2, 1'b1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_end_busy",  longint'(busy), 0);
    check("b2b_end_valid", longint'(valid), 0);

    // start pulses while rotating are ignored.
    @(negedge clk);
    drive(-12000, 4000, 25000);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive(16000, 16000, 0);
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = (k % 2 == 0);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    wait_valid(lat2);
    check("pulse_lat", longint'(lat + lat2), ITERS);
    check_result("pulse", -12000, 4000, 25000, ITERS + 2, 1'b1);
    @(posedge clk);
    #1;
    check("pulse_idle", longint'(busy), 0);

    // Fresh request after everything above completes normally.
    one_shot("fresh", 16384, 0, 0, 12, 1'b0);

    // Random sweep.
    for (int n = 0; n < 1000; n++) begin
      rx = int'($urandom_range(32768, 0)) - 16384;
      ry = int'($urandom_range(32768, 0)) - 16384;
      rz = int'($urandom_range(65535, 0)) - 32768;
      one_shot("rand", rx, ry, rz, ITERS + 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
